// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32IM pipeline: opcode fields, forwarding selects,
// divider sequencer states and the per-stage tracking record.
package rv_ctrl_pkg;

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   localparam int         DIV_CNT_W = 5;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_BUSY = 1'b1
   } div_state_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
      logic       load;
      logic       div;
   } stage_t;

   // x0 is never a forwarding source, even if a writer slipped through.
   function automatic logic rd_hit(input logic vld, input logic wen,
                                   input logic [4:0] rd, input logic [4:0] rs);
      return vld && wen && (rd == rs) && (rs != 5'd0);
   endfunction

endpackage

// File: rtl/div_sequencer.sv
// Divider occupancy sequencer: BUSY for DIV_LATENCY-1 cycles after start, counting only
// unfrozen cycles; freeze stalls both state and counter.
module div_sequencer
   import rv_ctrl_pkg::*;
#(
   parameter int DIV_LATENCY = 8
)
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic freeze,
   output logic busy
);

   localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_LATENCY - 2);

   div_state_e           r_state;
   div_state_e           w_state_nxt;
   logic [DIV_CNT_W-1:0] r_cnt;
   logic [DIV_CNT_W-1:0] w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DIV_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!freeze) begin
         case (r_state)
            DIV_IDLE: begin
               if (start) begin
                  w_state_nxt = DIV_BUSY;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
            DIV_BUSY: begin
               if (r_cnt == '0) w_state_nxt = DIV_IDLE;
               else             w_cnt_nxt   = r_cnt - DIV_CNT_W'(1);
            end
            default: w_state_nxt = DIV_IDLE;
         endcase
      end
   end

   assign busy = (r_state == DIV_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational hold/flush/bubble from tracked EX/MEM/WB state,
// registered forwarding selects; mem_wait freezes everything, divides hold EX for DIV_LATENCY.
module hazard_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int DIV_LATENCY = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_opcode,
   input  logic [2:0] id_func3,
   input  logic [6:0] id_func7,
   input  logic [4:0] id_rs1_index,
   input  logic [4:0] id_rs2_index,
   input  logic [4:0] id_rd_index,
   input  logic       ex_taken,
   input  logic       mem_wait,
   output logic       pc_hold,
   output logic       ifid_hold,
   output logic       idex_hold,
   output logic       exmem_hold,
   output logic       memwb_hold,
   output logic       ifid_flush,
   output logic       idex_bubble,
   output logic       exmem_bubble,
   output logic [1:0] fwd_rs1_sel,
   output logic [1:0] fwd_rs2_sel,
   output logic       div_busy
);

   logic     w_id_wen, w_rs1_use, w_rs2_use, w_id_load, w_id_div;
   logic     w_load_use, w_div_busy, w_div_start;
   stage_t   w_id_stage;
   stage_t   r_ex, r_mem, r_wb;
   fwd_sel_e w_fwd_rs1, w_fwd_rs2;
   fwd_sel_e r_fwd_rs1, r_fwd_rs2;

   assign w_id_wen  = id_valid && (id_rd_index != 5'd0) &&
                      (id_opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
                                         OPC_AUIPC, OPC_JAL, OPC_JALR});
   assign w_rs1_use = id_valid &&
                      (id_opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
                                         OPC_BRANCH, OPC_JALR});
   assign w_rs2_use = id_valid && (id_opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH});
   assign w_id_load = id_valid && (id_opcode == OPC_LOAD);
   assign w_id_div  = id_valid && (id_opcode == OPC_OP) &&
                      (id_func7 == F7_MULDIV) && id_func3[2];

   assign w_id_stage = '{valid: id_valid, rd: id_rd_index, wen: w_id_wen,
                         load: w_id_load, div: w_id_div};

   assign w_load_use = r_ex.valid && r_ex.load && r_ex.wen &&
                       ((w_rs1_use && (r_ex.rd == id_rs1_index)) ||
                        (w_rs2_use && (r_ex.rd == id_rs2_index)));

   always_comb begin
      w_fwd_rs1 = FWD_RF;
      w_fwd_rs2 = FWD_RF;
      if (w_rs1_use) begin
         if (rd_hit(r_ex.valid, r_ex.wen, r_ex.rd, id_rs1_index))        w_fwd_rs1 = FWD_EXMEM;
         else if (rd_hit(r_mem.valid, r_mem.wen, r_mem.rd, id_rs1_index)) w_fwd_rs1 = FWD_MEMWB;
      end
      if (w_rs2_use) begin
         if (rd_hit(r_ex.valid, r_ex.wen, r_ex.rd, id_rs2_index))        w_fwd_rs2 = FWD_EXMEM;
         else if (rd_hit(r_mem.valid, r_mem.wen, r_mem.rd, id_rs2_index)) w_fwd_rs2 = FWD_MEMWB;
      end
   end

   // A divide starts only on the edge that actually loads it into EX.
   assign w_div_start = w_id_div && !mem_wait && !w_div_busy && !ex_taken && !w_load_use;

   div_sequencer #(.DIV_LATENCY(DIV_LATENCY)) u_div_seq (
      .clk    (clk),
      .rst    (rst),
      .start  (w_div_start),
      .freeze (mem_wait),
      .busy   (w_div_busy)
   );

   always_comb begin
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      idex_hold    = 1'b0;
      exmem_hold   = 1'b0;
      memwb_hold   = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      if (mem_wait) begin
         pc_hold    = 1'b1;
         ifid_hold  = 1'b1;
         idex_hold  = 1'b1;
         exmem_hold = 1'b1;
         memwb_hold = 1'b1;
      end else if (w_div_busy) begin
         pc_hold      = 1'b1;
         ifid_hold    = 1'b1;
         idex_hold    = 1'b1;
         exmem_bubble = 1'b1;
      end else if (ex_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (w_load_use) begin
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex      <= '0;
         r_mem     <= '0;
         r_wb      <= '0;
         r_fwd_rs1 <= FWD_RF;
         r_fwd_rs2 <= FWD_RF;
      end else if (!mem_wait) begin
         r_wb  <= r_mem;
         r_mem <= w_div_busy ? '0 : r_ex;
         if (!w_div_busy) begin
            if (idex_bubble) begin
               r_ex      <= '0;
               r_fwd_rs1 <= FWD_RF;
               r_fwd_rs2 <= FWD_RF;
            end else begin
               r_ex      <= w_id_stage;
               r_fwd_rs1 <= w_fwd_rs1;
               r_fwd_rs2 <= w_fwd_rs2;
            end
         end
      end
   end

   assign fwd_rs1_sel = r_fwd_rs1;
   assign fwd_rs2_sel = r_fwd_rs2;
   assign div_busy    = w_div_busy;

   // WB entry and some attribute bits are tracked for the pipeline view but drive no control.
   logic w_unused_ok;
   assign w_unused_ok = ^{id_func3[1:0], r_ex.div, r_mem.load, r_mem.div, r_wb};

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32IM core. Takes the ID-stage decoded fields (opcode bits [6:2], func3, func7, register indices), privately tracks rd/write/load/div attributes of the instructions in EX, MEM and WB, and drives the pipeline-register hold, flush and bubble controls and the EX-stage forwarding selects. It also sequences the multi-cycle divider: EX is held for the divide latency while younger stages freeze.

## Interface
- DIV_LATENCY, 8: cycles a DIV/DIVU/REM/REMU occupies EX; legal range 2..32.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_opcode  in  5  inst[6:2] of ID instruction
- id_func3  in  3  inst[14:12]
- id_func7  in  7  inst[31:25]
- id_rs1_index, id_rs2_index, id_rd_index  in  5 each
- ex_taken  in  1  branch/jump redirect resolved in EX this cycle
- mem_wait  in  1  data memory not ready; whole pipeline must freeze
- pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold  out  1 each: register keeps its value
- ifid_flush  out  1  IF/ID loads a bubble
- idex_bubble  out  1  ID/EX loads a bubble
- exmem_bubble  out  1  EX/MEM loads a bubble
- fwd_rs1_sel, fwd_rs2_sel  out  2  for the EX instruction: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- div_busy  out  1  divider sequencer not IDLE

## Operation
- Decode of ID instruction: writes_rd = opcode ∈ {OP 01100, OP-IMM 00100, LOAD 00000, LUI 01101, AUIPC 00101, JAL 11011, JALR 11001} and rd≠0. uses_rs1 = {OP, OP-IMM, LOAD, STORE 01000, BRANCH 11000, JALR}. uses_rs2 = {OP, STORE, BRANCH}. is_div = OP, func7=0000001, func3[2]=1. Any field gated by id_valid.
- Tracking registers ex_*, mem_*, wb_* (valid, rd, wen, load, div) shift forward each cycle the corresponding pipeline register advances; a bubble enters as valid=0.
- Load-use: EX valid load, wen, rd matches a used rs of ID → pc_hold, ifid_hold, idex_bubble for one cycle.
- Forwarding, computed in ID, registered into EX with the instruction: match on current EX entry → 01; else match on current MEM entry → 10; else 00. rd=0 never matches. Register file is write-before-read, so WB needs no forward.
- Divider FSM: IDLE → BUSY when a div enters EX; counter loads DIV_LATENCY-2, decrements each unfrozen cycle; BUSY → IDLE when counter=0. In BUSY: pc_hold, ifid_hold, idex_hold, exmem_bubble.
- Redirect: ex_taken → ifid_flush, idex_bubble; no hold.
- Priority, highest first: mem_wait (all five holds, no bubbles/flushes, all tracking state and div counter frozen) > div BUSY > ex_taken > load-use. ex_taken with load-use in the same cycle: redirect only, no stall.

## Timing
- Reset: all outputs 0, fwd selects 00, all tracking entries invalid, FSM IDLE, counter 0. rst mid-divide returns to IDLE next edge.
- Hold/flush/bubble outputs are combinational from current state and ID inputs, same cycle.
- fwd selects registered; valid in the cycle the instruction is in EX and stable while idex_hold.
- Load-use penalty exactly 1 cycle; divide occupies EX exactly DIV_LATENCY unfrozen cycles, plus any mem_wait cycles.
- Back-to-back divides: second enters EX on the IDLE cycle and restarts BUSY with no extra gap.

## Structure
- Shared package rv_ctrl_pkg: 5-bit opcode constants, fwd-select encodings, divider state enum.
- One sub-module: div_sequencer (FSM + counter, inputs start/freeze, outputs busy).

## Test plan
- lw x5 then add x6,x5,x1 → one cycle pc_hold/ifid_hold/idex_bubble; add in EX with fwd_rs1_sel=10.
- add x5 then sub x7,x5,x5 → no stall; fwd_rs1_sel=fwd_rs2_sel=01.
- div x3,x1,x2 with DIV_LATENCY=8 → div_busy and idex_hold high 7 cycles, exmem_bubble each; following add x4,x3,x1 gets fwd 01.
- ex_taken asserted while ID holds a load-use consumer → ifid_flush and idex_bubble, no pc_hold.
- mem_wait held 3 cycles mid-divide → all holds high, counter frozen; divide completes 3 cycles later than nominal.
- rst asserted during BUSY → next cycle all outputs 0, div_busy 0; add x0 writer never triggers forwarding.
